// File: rtl/spi_line_fetcher_if.sv
// Handshake, random-access read port and SPI pins of spi_line_fetcher.
// master = line sequencer / pixel path / flash side, slave = the fetcher.
interface spi_line_fetcher_if #(
    parameter int IDX_W = 7
);
    logic             start;
    logic [23:0]      addr;
    logic             swap;
    logic [IDX_W-1:0] rd_index;
    logic             rd_data;
    logic             busy;
    logic             done;
    logic             spi_cs;
    logic             spi_sclk;
    logic             spi_mosi;
    logic             spi_miso;

    modport master (
        output start, addr, swap, rd_index, spi_miso,
        input  rd_data, busy, done, spi_cs, spi_sclk, spi_mosi
    );

    modport slave (
        input  start, addr, swap, rd_index, spi_miso,
        output rd_data, busy, done, spi_cs, spi_sclk, spi_mosi
    );
endinterface

// File: rtl/spi_line_fetcher.sv
// SPI flash line fetcher with ping-pong line buffers (READ 03h, or FAST READ 0Bh
// with 8 dummy bits when SPI_FAST_READ_EN is defined).
module spi_line_fetcher #(
    parameter int BUFFER_DEPTH = 128,
    parameter int IDX_W        = $clog2(BUFFER_DEPTH)
) (
    input logic               clk,
    input logic               reset,
    spi_line_fetcher_if.slave bus
);

`ifdef SPI_FAST_READ_EN
    localparam logic [7:0] CMD_BYTE = 8'h0B;
`else
    localparam logic [7:0] CMD_BYTE = 8'h03;
`endif
    localparam int CNT_W = (IDX_W > 5) ? IDX_W : 5;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, GAP} state_t;

    state_t            state;
    logic              ph;
    logic [CNT_W-1:0]  cnt;
    logic [30:0]       shreg;
    logic              sel;
    logic              swap_pend;
    logic [BUFFER_DEPTH-1:0] bank [2];

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            ph            <= 1'b0;
            cnt           <= '0;
            shreg         <= '0;
            sel           <= 1'b0;
            swap_pend     <= 1'b0;
            bus.spi_cs    <= 1'b0;
            bus.spi_sclk  <= 1'b0;
            bus.spi_mosi  <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state        <= CMD;
                        ph           <= 1'b0;
                        cnt          <= '0;
                        shreg        <= {CMD_BYTE[6:0], bus.addr};
                        swap_pend    <= bus.swap;
                        bus.spi_cs   <= 1'b1;
                        bus.busy     <= 1'b1;
                        bus.spi_sclk <= 1'b0;
                        bus.spi_mosi <= CMD_BYTE[7];
                    end else if (bus.swap) begin
                        sel <= ~sel;
                    end
                end
                GAP: begin
                    state <= IDLE;
                    if (bus.swap) sel <= ~sel;
                end
                default: begin
                    if (bus.swap) swap_pend <= 1'b1;
                    if (!ph) begin
                        ph           <= 1'b1;
                        bus.spi_sclk <= 1'b1;
                    end else begin
                        // end of a bit: sclk falls, MISO sampled, next MOSI bit presented
                        ph           <= 1'b0;
                        bus.spi_sclk <= 1'b0;
                        cnt          <= cnt + 1'b1;
                        shreg        <= {shreg[29:0], 1'b0};
                        bus.spi_mosi <= 1'b0;
                        case (state)
                            CMD: begin
                                bus.spi_mosi <= shreg[30];
                                if (cnt == CNT_W'(7)) begin
                                    state <= ADDR;
                                    cnt   <= '0;
                                end
                            end
                            ADDR: begin
                                if (cnt == CNT_W'(23)) begin
`ifdef SPI_FAST_READ_EN
                                    state <= DUMMY;
`else
                                    state <= DATA;
`endif
                                    cnt <= '0;
                                end else begin
                                    bus.spi_mosi <= shreg[30];
                                end
                            end
                            DUMMY: begin
                                if (cnt == CNT_W'(7)) begin
                                    state <= DATA;
                                    cnt   <= '0;
                                end
                            end
                            DATA: begin
                                if (cnt == CNT_W'(BUFFER_DEPTH - 1)) begin
                                    state      <= GAP;
                                    bus.spi_cs <= 1'b0;
                                    bus.busy   <= 1'b0;
                                    bus.done   <= 1'b1;
                                    swap_pend  <= 1'b0;
                                    if (swap_pend || bus.swap) sel <= ~sel;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    // Fill bank only; the display bank (~sel) is never written.
    always_ff @(posedge clk) begin
        if (!reset && state == DATA && ph)
            bank[sel][cnt[IDX_W-1:0]] <= bus.spi_miso;
    end

    assign bus.rd_data = bank[~sel][bus.rd_index];

endmodule

// File: tb/tb_spi_line_fetcher.sv
// Directed bench for spi_line_fetcher: flash model, frame scoreboard, bank model.
module tb_spi_line_fetcher;
    localparam int D   = 128;
    localparam int IW  = $clog2(D);
`ifdef SPI_FAST_READ_EN
    localparam int         HDR  = 40;
    localparam logic [7:0] CMDB = 8'h0B;
`else
    localparam int         HDR  = 32;
    localparam logic [7:0] CMDB = 8'h03;
`endif
    localparam int FRAME = 2 * (HDR + D);

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    spi_line_fetcher_if #(.IDX_W(IW)) bus ();
    spi_line_fetcher #(.BUFFER_DEPTH(D), .IDX_W(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int passed = 0, fails = 0, total = 0;
    logic [7:0]  flash_byte = 8'h00;
    int          bitn = 0, cs_cycles = 0, mosi_bad = 0, done_count = 0, exp_done = 0;
    logic        prev_cs = 1'b0;
    logic [31:0] mosi_word = '0;
    int          frm_len_q[$];
    logic [31:0] frm_word_q[$];
    int          exp_len_q[$];
    logic [31:0] exp_word_q[$];
    logic        exp_rd_q[$];
    logic [D-1:0] model_bank [2];
    logic        model_sel = 1'b0;
    logic        pend = 1'b0;

    // Flash model and frame monitor: drives MISO during sclk-high, records each CS frame.
    always @(negedge clk) begin
        if (bus.done) done_count++;
        if (bus.spi_mosi && (!bus.spi_cs || bitn >= 32)) mosi_bad++;
        if (bus.spi_cs) begin
            cs_cycles++;
            if (bus.spi_sclk) begin
                if (bitn < 32) mosi_word = {mosi_word[30:0], bus.spi_mosi};
                bus.spi_miso = (bitn >= HDR) ? flash_byte[3'(7 - ((bitn - HDR) % 8))] : 1'b0;
                bitn++;
            end
        end else begin
            if (prev_cs) begin
                frm_len_q.push_back(cs_cycles);
                frm_word_q.push_back(mosi_word);
            end
            cs_cycles = 0;
            bitn      = 0;
            mosi_word = '0;
            bus.spi_miso = 1'b0;
        end
        prev_cs = bus.spi_cs;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_model(input logic s, input logic [7:0] b, input int nbits);
        for (int k = 0; k < nbits; k++) model_bank[s][k] = b[3'(7 - k % 8)];
    endtask

    task automatic rd_check(input int idx);
        bus.rd_index = IW'(idx);
        exp_rd_q.push_back(model_bank[~model_sel][idx]);
        #1;
        check("rd_data", {31'b0, bus.rd_data}, {31'b0, exp_rd_q.pop_front()});
    endtask

    task automatic check_frame(input string tag);
        if (frm_len_q.size() == 0) begin
            check({tag, "_present"}, 0, 1);
        end else begin
            check({tag, "_cs_high_cycles"}, frm_len_q.pop_front(), exp_len_q.pop_front());
            check({tag, "_mosi_header"}, frm_word_q.pop_front(), exp_word_q.pop_front());
        end
    endtask

    task automatic idle_swap();
        bus.swap = 1'b1;
        @(posedge clk); #1;
        bus.swap = 1'b0;
        model_sel = ~model_sel;
        check("sel_after_idle_swap", {31'b0, dut.sel}, {31'b0, model_sel});
    endtask

    // Called at #1 after an edge with the DUT idle; returns in the cycle after GAP.
    task automatic run_fetch(input logic [23:0] a, input logic [7:0] b, input int swap_cyc,
                             input int busy_start_cyc, input bit start_in_done);
        logic       fsel;
        logic [7:0] cb;
        bit         seen;
        cb   = CMDB;
        fsel = model_sel;
        pend = 1'b0;
        seen = 1'b0;
        flash_byte = b;
        bus.addr  = a;
        bus.start = 1'b1;
        exp_word_q.push_back({CMDB, a});
        exp_len_q.push_back(FRAME);
        exp_done++;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.addr  = 24'h555555;
        check("accept_cs",   {31'b0, bus.spi_cs},   32'd1);
        check("accept_busy", {31'b0, bus.busy},     32'd1);
        check("accept_sclk", {31'b0, bus.spi_sclk}, 32'd0);
        check("accept_mosi", {31'b0, bus.spi_mosi}, {31'b0, cb[7]});
        for (int i = 1; i <= FRAME + 50 && !seen; i++) begin
            if (bus.done) begin
                seen = 1'b1;
                check("done_cycle_index", i, FRAME + 1);
                check("done_busy", {31'b0, bus.busy},   32'd0);
                check("done_cs",   {31'b0, bus.spi_cs}, 32'd0);
                if (pend) model_sel = ~model_sel;
                check("sel_at_done", {31'b0, dut.sel}, {31'b0, model_sel});
                fill_model(fsel, b, D);
                if (start_in_done) bus.start = 1'b1;
                @(posedge clk); #1;
                bus.start = 1'b0;
                check("gap_done", {31'b0, bus.done},   32'd0);
                check("gap_cs",   {31'b0, bus.spi_cs}, 32'd0);
                check("gap_busy", {31'b0, bus.busy},   32'd0);
                check_frame("frame");
                check("done_pulses", done_count, exp_done);
            end else begin
                check("sel_during_fetch", {31'b0, dut.sel}, {31'b0, model_sel});
                rd_check(int'($urandom_range(D - 1)));
                if (swap_cyc > 0 && (i == swap_cyc || i == swap_cyc + 10)) begin
                    bus.swap = 1'b1;
                    pend     = 1'b1;
                end
                if (busy_start_cyc > 0 && i == busy_start_cyc) bus.start = 1'b1;
                @(posedge clk); #1;
                bus.swap  = 1'b0;
                bus.start = 1'b0;
            end
        end
        if (!seen) check("done_timeout", 0, 1);
    endtask

    initial begin
        int   quiet;
        logic fsel;
        bus.start    = 1'b0;
        bus.swap     = 1'b0;
        bus.addr     = '0;
        bus.rd_index = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_cs",   {31'b0, bus.spi_cs},   32'd0);
        check("rst_sclk", {31'b0, bus.spi_sclk}, 32'd0);
        check("rst_mosi", {31'b0, bus.spi_mosi}, 32'd0);
        check("rst_busy", {31'b0, bus.busy},     32'd0);
        check("rst_done", {31'b0, bus.done},     32'd0);
        check("rst_sel",  {31'b0, dut.sel},      32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Plain fetch of 0xA5 into bank 0; display stays on the unfilled bank.
        run_fetch(24'h000810, 8'hA5, 0, 0, 1'b0);
        check("sel_before_swap", {31'b0, dut.sel}, 32'd0);
        idle_swap();
        for (int i = 0; i < 8; i++) rd_check(i);
        for (int i = D - 8; i < D; i++) rd_check(i);

        // Two swaps mid-fetch collapse to one at done; starts while busy and in done cycle ignored.
        run_fetch(24'h123456, 8'h3C, 50, 80, 1'b1);
        // Back-to-back fetch at the earliest legal edge.
        run_fetch(24'hABCDEF, 8'h96, 0, 0, 1'b0);
        for (int i = 0; i < 8; i++) rd_check(i);
        idle_swap();
        for (int i = 0; i < 8; i++) rd_check(i);

        // Reset in cycle 100 of a fetch into bank 1.
        fsel = model_sel;
        flash_byte = 8'hFF;
        bus.addr   = 24'h000000;
        bus.start  = 1'b1;
        exp_word_q.push_back({CMDB, 24'h000000});
        exp_len_q.push_back(100);
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 1; i < 100; i++) begin
            rd_check(int'($urandom_range(D - 1)));
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_cs",   {31'b0, bus.spi_cs},   32'd0);
        check("midrst_sclk", {31'b0, bus.spi_sclk}, 32'd0);
        check("midrst_mosi", {31'b0, bus.spi_mosi}, 32'd0);
        check("midrst_busy", {31'b0, bus.busy},     32'd0);
        check("midrst_done", {31'b0, bus.done},     32'd0);
        check("midrst_sel",  {31'b0, dut.sel},      32'd0);
        reset = 1'b0;
        model_sel = 1'b0;
        fill_model(fsel, 8'hFF, 49 - HDR);
        quiet = 0;
        repeat (FRAME + 20) begin
            @(posedge clk); #1;
            if (bus.done || bus.spi_cs) quiet++;
        end
        check("midrst_quiet_cycles", quiet, 0);
        check("midrst_done_pulses", done_count, exp_done);
        check_frame("midrst_frame");
        for (int i = 0; i < 32; i++) rd_check(i);

        check("mosi_outside_cmd_addr", mosi_bad, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
